// File: rtl/instr_phase_sequencer_pkg.sv
// Shared state encoding and control-word field positions for the LEGv8 multi-cycle sequencer.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_RSVD   = 3'd7
  } state_t;

  localparam int CW_REGW  = 9;
  localparam int CW_RAMW  = 8;
  localparam int CW_ENMEM = 7;
  localparam int CW_PS_HI = 31;
  localparam int CW_PS_LO = 30;

  localparam logic [31:0] HALT_INSTR = 32'h0000_0000;

  function automatic logic is_halt(input logic [31:0] instr);
    return (instr == HALT_INSTR);
  endfunction

endpackage

// File: rtl/instr_phase_sequencer_phase_timer.sv
// Cycle counter for the current sequencer state; cleared whenever the state changes,
// flags when the count reaches the terminal value supplied for that state.
module phase_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic [7:0] term,
  output logic       at_term
);

  logic [7:0] count_r;

  // Count cycles in the current state; saturate so a long stay in IDLE cannot wrap into a false terminal hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= 8'd0;
    end else if (clear) begin
      count_r <= 8'd0;
    end else if (count_r != 8'hFF) begin
      count_r <= count_r + 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign at_term = (count_r == term);

endmodule

// File: rtl/instr_phase_sequencer.sv
// Multi-cycle instruction sequencer: fetch, wait out the registered decode, then gate
// the control word's write strobes into EXEC / MEM / WB and retire one instruction.
module instr_phase_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int DECODE_CYCLES = 1,
  parameter int FETCH_TIMEOUT = 16,
  parameter int MEM_TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [31:0] instr_in,
  input  logic        rom_valid,
  input  logic [31:0] cw_in,
  input  logic        mem_ready,
  output logic        rom_req,
  output logic        ir_load,
  output logic [31:0] ir,
  output logic        alu_en,
  output logic        mem_req,
  output logic        mem_we,
  output logic        reg_we,
  output logic        pc_en,
  output logic        retire,
  output logic [31:0] retired_cnt,
  output logic        halted,
  output logic        fault,
  output logic [2:0]  state
);

  localparam logic [7:0] DECODE_TERM = 8'(DECODE_CYCLES - 1);
  localparam logic [7:0] FETCH_TERM  = 8'(FETCH_TIMEOUT - 1);
  localparam logic [7:0] MEM_TERM    = 8'(MEM_TIMEOUT - 1);

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] ir_r;
  logic [31:0] cnt_r;
  logic        fault_r;
  logic        fault_set_s;
  logic        timer_clear_s;
  logic [7:0]  timer_term_s;
  logic        timer_at_term_s;
  logic        ir_load_s;
  logic        unused_cw_s;

  phase_timer u_phase_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear_s),
    .term    (timer_term_s),
    .at_term (timer_at_term_s)
  );

  // Select the terminal count that matters for the current state.
  always_comb begin
    timer_term_s = 8'hFF;
    case (state_r)
      ST_FETCH:  timer_term_s = FETCH_TERM;
      ST_DECODE: timer_term_s = DECODE_TERM;
      ST_MEM:    timer_term_s = MEM_TERM;
      default:   timer_term_s = 8'hFF;
    endcase
  end

  // Next-state logic; run is only looked at in IDLE and WB so an instruction always completes.
  always_comb begin
    state_nxt_s = state_r;
    fault_set_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (run) state_nxt_s = ST_FETCH;
        else     state_nxt_s = ST_IDLE;
      end
      ST_FETCH: begin
        if (rom_valid) begin
          if (is_halt(instr_in)) state_nxt_s = ST_HALT;
          else                   state_nxt_s = ST_DECODE;
        end else if (timer_at_term_s) begin
          state_nxt_s = ST_HALT;
          fault_set_s = 1'b1;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (timer_at_term_s) state_nxt_s = ST_EXEC;
        else                 state_nxt_s = ST_DECODE;
      end
      ST_EXEC: begin
        if (cw_in[CW_ENMEM]) state_nxt_s = ST_MEM;
        else                 state_nxt_s = ST_WB;
      end
      ST_MEM: begin
        // A ready on the final allowed cycle still wins over the timeout.
        if (mem_ready) begin
          state_nxt_s = ST_WB;
        end else if (timer_at_term_s) begin
          state_nxt_s = ST_HALT;
          fault_set_s = 1'b1;
        end else begin
          state_nxt_s = ST_MEM;
        end
      end
      ST_WB: begin
        if (run) state_nxt_s = ST_FETCH;
        else     state_nxt_s = ST_IDLE;
      end
      ST_HALT: state_nxt_s = ST_HALT;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  assign timer_clear_s = (state_nxt_s != state_r);
  assign ir_load_s     = (state_r == ST_FETCH) && rom_valid;

  // State, instruction register, retire counter and sticky fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      ir_r    <= 32'h0000_0000;
      cnt_r   <= 32'h0000_0000;
      fault_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (ir_load_s) ir_r <= instr_in;
      else           ir_r <= ir_r;
      if (state_r == ST_WB) cnt_r <= cnt_r + 32'd1;
      else                  cnt_r <= cnt_r;
      if (fault_set_s) fault_r <= 1'b1;
      else             fault_r <= fault_r;
    end
  end

  assign rom_req     = (state_r == ST_FETCH);
  assign ir_load     = ir_load_s;
  assign ir          = ir_r;
  assign alu_en      = (state_r == ST_EXEC);
  assign mem_req     = (state_r == ST_MEM);
  assign mem_we      = (state_r == ST_MEM) && cw_in[CW_RAMW];
  assign reg_we      = (state_r == ST_WB) && cw_in[CW_REGW];
  assign pc_en       = (state_r == ST_WB);
  assign retire      = (state_r == ST_WB);
  assign retired_cnt = cnt_r;
  assign halted      = (state_r == ST_HALT);
  assign fault       = fault_r;
  assign state       = state_r;

  // Control-word fields that belong to other datapath blocks.
  assign unused_cw_s = &{1'b0, cw_in[CW_PS_HI:CW_PS_LO], cw_in[29:10], cw_in[6:0]};

endmodule

// File: tb/tb_instr_phase_sequencer.sv
// Table-driven bench: hand-written corner sequences plus a randomized program whose
// cycle-by-cycle expectations are expanded from per-instruction phase lengths.
module tb_instr_phase_sequencer;

  localparam int DEC = 1;
  localparam int FTO = 16;
  localparam int MTO = 16;

  localparam logic [7:0] SB_NONE  = 8'b0000_0000;
  localparam logic [7:0] SB_FETCH = 8'b1000_0000;
  localparam logic [7:0] SB_LOAD  = 8'b1100_0000;
  localparam logic [7:0] SB_EXEC  = 8'b0010_0000;
  localparam logic [7:0] SB_MEMR  = 8'b0001_0000;
  localparam logic [7:0] SB_MEMW  = 8'b0001_1000;
  localparam logic [7:0] SB_WB    = 8'b0000_0011;
  localparam logic [7:0] SB_WBR   = 8'b0000_0111;

  localparam logic [31:0] ADD     = 32'h8B02_0020;
  localparam logic [31:0] STUR    = 32'hF800_0000;
  localparam logic [31:0] LDUR    = 32'hF840_0000;
  localparam logic [31:0] CW_ADD  = 32'h0000_0200;
  localparam logic [31:0] CW_STUR = 32'h0000_0180;
  localparam logic [31:0] CW_LDUR = 32'h0000_0280;

  logic        clk = 1'b0;
  logic        rst, run, rom_valid, mem_ready;
  logic [31:0] instr_in, cw_in;
  logic        rom_req, ir_load, alu_en, mem_req, mem_we, reg_we, pc_en, retire, halted, fault;
  logic [31:0] ir, retired_cnt;
  logic [2:0]  state;

  always #5 clk = ~clk;

  instr_phase_sequencer #(
    .DECODE_CYCLES (DEC),
    .FETCH_TIMEOUT (FTO),
    .MEM_TIMEOUT   (MTO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .instr_in    (instr_in),
    .rom_valid   (rom_valid),
    .cw_in       (cw_in),
    .mem_ready   (mem_ready),
    .rom_req     (rom_req),
    .ir_load     (ir_load),
    .ir          (ir),
    .alu_en      (alu_en),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .reg_we      (reg_we),
    .pc_en       (pc_en),
    .retire      (retire),
    .retired_cnt (retired_cnt),
    .halted      (halted),
    .fault       (fault),
    .state       (state)
  );

  typedef struct {
    logic        rst;
    logic        run;
    logic        rv;
    logic [31:0] instr;
    logic [31:0] cw;
    logic        mr;
    logic [2:0]  st;
    logic [7:0]  sb;
    logic [31:0] ir;
    logic [31:0] cnt;
    logic        halted;
    logic        fault;
  } vec_t;

  vec_t  vq[$];
  string nq[$];
  int    passed = 0;
  int    total  = 0;

  task automatic add(input string nm, input int r, input int rn, input int rv,
                     input logic [31:0] ins, input logic [31:0] cw, input int mr,
                     input int st, input logic [7:0] sb, input logic [31:0] ir_e,
                     input logic [31:0] cnt_e, input int h, input int f);
    vec_t v;
    v.rst = (r != 0);   v.run = (rn != 0); v.rv = (rv != 0);
    v.instr = ins;      v.cw = cw;         v.mr = (mr != 0);
    v.st = 3'(st);      v.sb = sb;         v.ir = ir_e;
    v.cnt = cnt_e;      v.halted = (h != 0); v.fault = (f != 0);
    vq.push_back(v);
    nq.push_back(nm);
  endtask

  task automatic check(input string nm, input logic ok);
    total++;
    if (ok === 1'b1) passed++;
    else $display("FAIL %s: state=%0d halted=%b fault=%b cnt=%h ir=%h strobes=%b",
                  nm, state, halted, fault, retired_cnt, ir,
                  {rom_req, ir_load, alu_en, mem_req, mem_we, reg_we, pc_en, retire});
  endtask

  function automatic int rbit();
    return int'($urandom & 32'd1);
  endfunction

  initial begin
    logic [76:0] obs, exp_v;
    logic [31:0] cur_ir, cur_cnt;
    int df, dm;
    logic [31:0] ins, cw;

    rst = 1'b1; run = 1'b0; rom_valid = 1'b0; mem_ready = 1'b0;
    instr_in = 32'h0; cw_in = 32'h0;

    // ADD, immediate fetch: ir_load @1, alu_en @3, WB @4
    add("reset",      0,1,0,32'h0,32'h0,0,   0,SB_NONE,32'h0,32'd0,0,0);
    add("add_fetch",  0,1,1,ADD,CW_ADD,0,    1,SB_LOAD,32'h0,32'd0,0,0);
    add("add_dec",    0,1,0,32'h0,CW_ADD,0,  2,SB_NONE,ADD,32'd0,0,0);
    add("add_exec",   0,1,0,32'h0,CW_ADD,0,  3,SB_EXEC,ADD,32'd0,0,0);
    add("add_wb",     0,0,0,32'h0,CW_ADD,0,  5,SB_WBR,ADD,32'd0,0,0);
    add("add_idle",   0,0,0,32'h0,32'h0,0,   0,SB_NONE,ADD,32'd1,0,0);
    add("idle_run",   0,1,0,32'h0,32'h0,0,   0,SB_NONE,ADD,32'd1,0,0);
    // STUR with ready on third MEM cycle; stray rom_valid/mem_ready in DECODE/EXEC ignored
    add("stur_fetch", 0,1,1,STUR,CW_STUR,0,  1,SB_LOAD,ADD,32'd1,0,0);
    add("stur_dec",   0,1,1,ADD,CW_STUR,1,   2,SB_NONE,STUR,32'd1,0,0);
    add("stur_exec",  0,1,0,32'h0,CW_STUR,1, 3,SB_EXEC,STUR,32'd1,0,0);
    for (int k = 0; k < 3; k++)
      add("stur_mem", 0,1,0,32'h0,CW_STUR,int'(k == 2), 4,SB_MEMW,STUR,32'd1,0,0);
    add("stur_wb",    0,1,0,32'h0,CW_STUR,0, 5,SB_WB,STUR,32'd1,0,0);
    // run dropped while in flight
    add("rd_fetch",   0,0,1,ADD,CW_ADD,0,    1,SB_LOAD,STUR,32'd2,0,0);
    add("rd_dec",     0,0,0,32'h0,CW_ADD,0,  2,SB_NONE,ADD,32'd2,0,0);
    add("rd_exec",    0,0,0,32'h0,CW_ADD,0,  3,SB_EXEC,ADD,32'd2,0,0);
    add("rd_wb",      0,0,0,32'h0,CW_ADD,0,  5,SB_WBR,ADD,32'd2,0,0);
    add("rd_idle",    0,0,1,ADD,32'h0,0,     0,SB_NONE,ADD,32'd3,0,0);
    add("rd_idle2",   0,1,0,32'h0,32'h0,0,   0,SB_NONE,ADD,32'd3,0,0);
    // reset while in MEM, with mem_ready present on the reset edge
    add("ld_fetch",   0,1,1,LDUR,CW_LDUR,0,  1,SB_LOAD,ADD,32'd3,0,0);
    add("ld_dec",     0,1,0,32'h0,CW_LDUR,0, 2,SB_NONE,LDUR,32'd3,0,0);
    add("ld_exec",    0,1,0,32'h0,CW_LDUR,0, 3,SB_EXEC,LDUR,32'd3,0,0);
    add("ld_mem_rst", 1,1,0,32'h0,CW_LDUR,1, 4,SB_MEMR,LDUR,32'd3,0,0);
    add("post_rst",   0,0,0,32'h0,CW_LDUR,1, 0,SB_NONE,32'h0,32'd0,0,0);
    // halt encoding
    add("h_idle",     0,1,0,32'h0,32'h0,0,   0,SB_NONE,32'h0,32'd0,0,0);
    add("h_fetch",    0,1,1,32'h0,CW_ADD,0,  1,SB_LOAD,32'h0,32'd0,0,0);
    add("halted",     0,1,1,ADD,CW_ADD,1,    6,SB_NONE,32'h0,32'd0,1,0);
    add("halted2",    0,1,1,ADD,CW_ADD,1,    6,SB_NONE,32'h0,32'd0,1,0);
    add("h_rst",      1,0,0,32'h0,32'h0,0,   6,SB_NONE,32'h0,32'd0,1,0);
    // fetch timeout
    add("to_idle",    0,1,0,32'h0,32'h0,0,   0,SB_NONE,32'h0,32'd0,0,0);
    for (int k = 0; k < FTO; k++)
      add("to_fetch", 0,1,0,ADD,32'h0,0,     1,SB_FETCH,32'h0,32'd0,0,0);
    add("to_fault",   0,1,1,ADD,32'h0,0,     6,SB_NONE,32'h0,32'd0,1,1);
    add("to_rst",     1,0,0,32'h0,32'h0,0,   6,SB_NONE,32'h0,32'd0,1,1);
    add("to_clear",   0,0,0,32'h0,32'h0,0,   0,SB_NONE,32'h0,32'd0,0,0);
    // memory timeout
    add("mt_idle",    0,1,0,32'h0,32'h0,0,   0,SB_NONE,32'h0,32'd0,0,0);
    add("mt_fetch",   0,1,1,STUR,CW_STUR,0,  1,SB_LOAD,32'h0,32'd0,0,0);
    add("mt_dec",     0,1,0,32'h0,CW_STUR,0, 2,SB_NONE,STUR,32'd0,0,0);
    add("mt_exec",    0,1,0,32'h0,CW_STUR,0, 3,SB_EXEC,STUR,32'd0,0,0);
    for (int k = 0; k < MTO; k++)
      add("mt_mem",   0,1,0,32'h0,CW_STUR,0, 4,SB_MEMW,STUR,32'd0,0,0);
    add("mt_fault",   0,1,0,32'h0,CW_STUR,1, 6,SB_NONE,STUR,32'd0,1,1);
    add("mt_rst",     1,0,0,32'h0,CW_STUR,0, 6,SB_NONE,STUR,32'd0,1,1);
    add("mt_clear",   0,0,0,32'h0,32'h0,0,   0,SB_NONE,32'h0,32'd0,0,0);

    // randomized program: each instruction expands into its phase sequence
    cur_ir = 32'h0; cur_cnt = 32'd0;
    add("r_idle", 0,1,rbit(),$urandom,$urandom,rbit(), 0,SB_NONE,cur_ir,cur_cnt,0,0);
    for (int k = 0; k < 30; k++) begin
      df  = int'($urandom_range(4, 0));
      dm  = int'($urandom_range(5, 0));
      ins = $urandom | 32'h1;
      cw  = $urandom;
      for (int i = 0; i <= df; i++)
        add("r_fetch", 0,rbit(),int'(i == df),(i == df) ? ins : $urandom,$urandom,rbit(),
            1,(i == df) ? SB_LOAD : SB_FETCH,cur_ir,cur_cnt,0,0);
      cur_ir = ins;
      for (int i = 0; i < DEC; i++)
        add("r_dec", 0,rbit(),rbit(),$urandom,cw,rbit(), 2,SB_NONE,cur_ir,cur_cnt,0,0);
      add("r_exec", 0,rbit(),rbit(),$urandom,cw,rbit(), 3,SB_EXEC,cur_ir,cur_cnt,0,0);
      if (cw[7]) begin
        for (int j = 0; j <= dm; j++)
          add("r_mem", 0,rbit(),rbit(),$urandom,cw,int'(j == dm),
              4,{3'b000,1'b1,cw[8],3'b000},cur_ir,cur_cnt,0,0);
      end
      add("r_wb", 0,(k == 29) ? 0 : 1,rbit(),$urandom,cw,rbit(),
          5,{5'b00000,cw[9],2'b11},cur_ir,cur_cnt,0,0);
      cur_cnt = cur_cnt + 32'd1;
    end
    add("r_end", 0,0,rbit(),$urandom,$urandom,rbit(), 0,SB_NONE,cur_ir,cur_cnt,0,0);

    repeat (2) @(posedge clk);
    #1;
    check("reset_state",
          (state === 3'd0) && (ir === 32'h0) && (retired_cnt === 32'd0) &&
          (halted === 1'b0) && (fault === 1'b0) &&
          ({rom_req, ir_load, alu_en, mem_req, mem_we, reg_we, pc_en, retire} === 8'b0000_0000));
    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].rst; run = vq[i].run; rom_valid = vq[i].rv;
      instr_in = vq[i].instr; cw_in = vq[i].cw; mem_ready = vq[i].mr;
      @(negedge clk);
      obs   = {state, rom_req, ir_load, alu_en, mem_req, mem_we, reg_we, pc_en, retire,
               halted, fault, ir, retired_cnt};
      exp_v = {vq[i].st, vq[i].sb, vq[i].halted, vq[i].fault, vq[i].ir, vq[i].cnt};
      total++;
      if (obs === exp_v) passed++;
      else $display("FAIL %s[%0d]: got st=%0d sb=%b h/f=%b ir=%h cnt=%h, expected st=%0d sb=%b h/f=%b ir=%h cnt=%h",
                    nq[i], i, obs[76:74], obs[73:66], obs[65:64], obs[63:32], obs[31:0],
                    exp_v[76:74], exp_v[73:66], exp_v[65:64], exp_v[63:32], exp_v[31:0]);
      if ((nq[i] == "to_fault") || (nq[i] == "mt_fault"))
        check({"expired_wait_", nq[i]},
              (fault === 1'b1) && (halted === 1'b1) && (state === 3'd6) &&
              (reg_we === 1'b0) && (pc_en === 1'b0) && (retire === 1'b0));
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
